// File: rtl/ss_pkt_arbiter.sv
// ss_pkt_arbiter: N-input to 1-output stream arbiter with packet-locked
// round-robin grants and a registered output stage.
// Optional build macro SS_ARB_SRC_TAG_EN: when defined, the low SRC_W bits of
// out_user carry the index of the input that owns the current packet.
module ss_pkt_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 8,
  parameter int SRC_W  = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_valid,
  output logic [N_IN-1:0]          in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [N_IN*KEEP_W-1:0]   in_keep,
  input  logic [N_IN-1:0]          in_last,
  input  logic [N_IN*USER_W-1:0]   in_user,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [KEEP_W-1:0]        out_keep,
  output logic                     out_last,
  output logic [USER_W-1:0]        out_user,
  output logic [N_IN-1:0]          grant,
  output logic                     busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  owner;
  logic [SRC_W-1:0]  sel_idx;
  logic              sel_found;
  logic              accept;
  logic              in_fire;
  logic [USER_W-1:0] user_next;

  logic [DATA_W-1:0] data_arr [N_IN];
  logic [KEEP_W-1:0] keep_arr [N_IN];
  logic [USER_W-1:0] user_arr [N_IN];

  genvar gi;
  for (gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
    assign keep_arr[gi] = in_keep[gi*KEEP_W +: KEEP_W];
    assign user_arr[gi] = in_user[gi*USER_W +: USER_W];
  end

  // Round-robin search: first requesting input starting at rr_ptr, wrapping.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (!sel_found && in_valid[SRC_W'((int'(rr_ptr) + k) % N_IN)]) begin
        sel_found = 1'b1;
        sel_idx   = SRC_W'((int'(rr_ptr) + k) % N_IN);
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle;
  // only the owner sees that, everyone else is held off by the zero grant bits.
  assign accept   = !out_valid || out_ready;
  assign in_ready = grant & {N_IN{accept}};
  assign in_fire  = |(in_valid & in_ready);
  assign busy     = (state == LOCK);

`ifdef SS_ARB_SRC_TAG_EN
  localparam logic [USER_W-1:0] SRC_MASK = USER_W'((1 << SRC_W) - 1);

  if (USER_W < SRC_W) begin : g_user_width_check
    $error("ss_pkt_arbiter: USER_W must be at least SRC_W when source tagging is enabled");
  end

  assign user_next = (user_arr[owner] & ~SRC_MASK) | USER_W'(owner);
`else
  assign user_next = user_arr[owner];
`endif

  // Arbitration FSM, round-robin pointer and the registered output slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state <= LOCK;
            owner <= sel_idx;
            grant <= {{(N_IN-1){1'b0}}, 1'b1} << sel_idx;
          end
        end
        LOCK: begin
          if (in_fire && in_last[owner]) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (owner == SRC_W'(N_IN - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase

      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= data_arr[owner];
        out_keep  <= keep_arr[owner];
        out_last  <= in_last[owner];
        out_user  <= user_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ss_pkt_arbiter.sv
// tb_ss_pkt_arbiter: directed scoreboard bench for ss_pkt_arbiter (N_IN=4).
// Expected output beats are queued when stimulus is issued; an independent
// monitor pops and compares on every output transfer.
module tb_ss_pkt_arbiter;

  localparam int N_IN   = 4;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int USER_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  logic                    clk;
  logic                    rst;
  logic [N_IN-1:0]         in_valid;
  logic [N_IN-1:0]         in_ready;
  logic [N_IN*DATA_W-1:0]  in_data;
  logic [N_IN*KEEP_W-1:0]  in_keep;
  logic [N_IN-1:0]         in_last;
  logic [N_IN*USER_W-1:0]  in_user;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [KEEP_W-1:0]       out_keep;
  logic                    out_last;
  logic [USER_W-1:0]       out_user;
  logic [N_IN-1:0]         grant;
  logic                    busy;

  beat_t           src_q [N_IN][$];
  beat_t           exp_q [$];
  logic [N_IN-1:0] fire_hist [$];
  logic [N_IN-1:0] fire;
  logic            rec_en;
  int              errors;
  int              checks;

  ss_pkt_arbiter #(
    .N_IN   (N_IN),
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_user  (out_user),
    .grant     (grant),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand model of the user sideband as seen at the output.
  function automatic logic [USER_W-1:0] tag_user(input int src, input logic [USER_W-1:0] u);
    logic [1:0] s;
    s = src[1:0];
`ifdef SS_ARB_SRC_TAG_EN
    tag_user = {u[USER_W-1:2], s};
`else
    tag_user = u | {6'd0, s & 2'b00};
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Queue an n-beat packet on input src; the first n_exp beats are expected out.
  task automatic applyStimulus(input int src, input int n, input int n_exp,
                               input logic [63:0] base, input logic [USER_W-1:0] user);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 64'(k);
      b.keep = (k == n - 1) ? 8'h0F : 8'hFF;
      b.last = (k == n - 1);
      b.user = user;
      src_q[src].push_back(b);
      if (k < n_exp) begin
        b.user = tag_user(src, user);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic bit srcs_pending();
    srcs_pending = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (src_q[i].size() != 0) srcs_pending = 1'b1;
  endfunction

  task automatic waitDrain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || srcs_pending()) && n < limit) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0 || srcs_pending()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout with %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic waitGrant(input string name, input logic [N_IN-1:0] g, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (grant !== g && n < limit);
    checkOutput(name, 64'(grant), 64'(g));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N_IN; i++) src_q[i].delete();
    rst = 1'b1;
  endtask

  // Source driver: present queue heads on the falling edge, retire on transfer.
  initial begin
    in_valid = '0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = '0;
    in_user  = '0;
    fire     = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_IN; i++) begin
        if (src_q[i].size() > 0) begin
          in_valid[i]                  = 1'b1;
          in_data[i*DATA_W +: DATA_W]  = src_q[i][0].data;
          in_keep[i*KEEP_W +: KEEP_W]  = src_q[i][0].keep;
          in_last[i]                   = src_q[i][0].last;
          in_user[i*USER_W +: USER_W]  = src_q[i][0].user;
        end else begin
          in_valid[i] = 1'b0;
          in_last[i]  = 1'b0;
        end
      end
      #1;
      fire = in_valid & in_ready;
      @(posedge clk);
      if (rec_en) fire_hist.push_back(fire & {N_IN{rst}});
      for (int i = 0; i < N_IN; i++)
        if (fire[i] && rst) void'(src_q[i].pop_front());
    end
  end

  // Output monitor: every output transfer must match the head of the scoreboard.
  initial begin
    beat_t act;
    beat_t exp_b;
    forever begin
      @(negedge clk);
      #1;
      if (rst && out_valid && out_ready) begin
        act = {out_data, out_keep, out_last, out_user};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_beat: got unexpected beat %h, required none", act);
        end else begin
          exp_b = exp_q.pop_front();
          if (act !== exp_b) begin
            errors++;
            $display("[TB] FAIL out_beat: got %h expected %h", act, exp_b);
          end
        end
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int fires;
    int run;
    int n;
    bit started;
    int gaps [$];

    errors    = 0;
    checks    = 0;
    rec_en    = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_fields", {out_data[31:0], out_keep, out_last, out_user},
                {32'd0, 8'd0, 1'b0, 8'd0});
    checkOutput("rst_grant_busy", {grant, busy, in_ready}, {4'd0, 1'b0, 4'd0});
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single 3-beat packet on input 2.
    $display("[TB] test 1: single request on input 2");
    @(posedge clk);
    #1;
    applyStimulus(2, 3, 3, 64'hA0, 8'h00);
    @(negedge clk);
    #2;
    checkOutput("t1_grant_idle", 64'(grant), 64'd0);
    checkOutput("t1_ready_idle", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2;
    checkOutput("t1_grant", 64'(grant), 64'b0100);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    waitDrain("t1_drain", 50);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);
    checkOutput("t1_rr_ptr", 64'(dut.rr_ptr), 64'd3);

    // All four inputs requesting with 2-beat packets.
    $display("[TB] test 2: round-robin rotation");
    resetDut();
    fire_hist.delete();
    rec_en = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 2, 2, 64'h100, 8'h10);
    applyStimulus(1, 2, 2, 64'h110, 8'h14);
    applyStimulus(2, 2, 2, 64'h120, 8'h18);
    applyStimulus(3, 2, 2, 64'h130, 8'h1C);
    applyStimulus(0, 2, 2, 64'h140, 8'h20);
    waitDrain("t2_drain", 100);
    rec_en  = 1'b0;
    fires   = 0;
    run     = 0;
    started = 1'b0;
    foreach (fire_hist[h]) begin
      if (fire_hist[h] != '0) begin
        fires++;
        if (started && run > 0) gaps.push_back(run);
        run     = 0;
        started = 1'b1;
      end else if (started) begin
        run++;
      end
    end
    checkOutput("t2_fire_count", 64'(fires), 64'd10);
    checkOutput("t2_bubble_count", 64'(gaps.size()), 64'd4);
    foreach (gaps[g]) checkOutput("t2_bubble_len", 64'(gaps[g]), 64'd1);

    // Lock hold: input 0 requests while input 1 owns the output.
    $display("[TB] test 3: lock hold");
    resetDut();
    @(posedge clk);
    #1;
    applyStimulus(1, 3, 3, 64'h200, 8'h20);
    waitGrant("t3_grant1", 4'b0010, 20);
    @(posedge clk);
    #1;
    applyStimulus(0, 2, 2, 64'h210, 8'h30);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      #2;
      if (!grant[1]) break;
      checkOutput("t3_hold_in0", 64'(in_ready[0]), 64'd0);
      n++;
    end
    checkOutput("t3_rr_ptr", 64'(dut.rr_ptr), 64'd2);
    checkOutput("t3_bubble_grant", 64'(grant), 64'd0);
    waitGrant("t3_grant0", 4'b0001, 5);
    waitDrain("t3_drain", 50);

    // Backpressure for 5 cycles mid-packet on input 3.
    $display("[TB] test 4: backpressure");
    resetDut();
    @(posedge clk);
    #1;
    applyStimulus(3, 4, 4, 64'h300, 8'h40);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (src_q[3].size() != 2 && n < 30);
    checkOutput("t4_reach_beat2", 64'(src_q[3].size()), 64'd2);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      checkOutput("t4_hold_data", out_data, 64'h301);
      checkOutput("t4_hold_ctl", {out_valid, out_last, in_ready[3], out_keep, out_user},
                  {1'b1, 1'b0, 1'b0, 8'hFF, tag_user(3, 8'h40)});
      @(negedge clk);
    end
    out_ready = 1'b1;
    waitDrain("t4_drain", 50);

    // Asynchronous reset during a 4-beat packet on input 1.
    $display("[TB] test 5: async reset mid-packet");
    resetDut();
    @(posedge clk);
    #1;
    applyStimulus(1, 4, 2, 64'h400, 8'h50);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (src_q[1].size() != 2 && n < 30);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_rst_data", out_data, 64'd0);
    checkOutput("t5_rst_ctl", {out_keep, out_last, out_user, grant, busy, in_ready},
                {8'd0, 1'b0, 8'd0, 4'd0, 1'b0, 4'd0});
    checkOutput("t5_sb_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    src_q[1].delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3, 1, 1, 64'h500, 8'h60);
    waitGrant("t5_grant3", 4'b1000, 10);
    waitDrain("t5_drain", 50);

    // User sideband passthrough / source tagging on input 2.
    $display("[TB] test 6: user sideband");
    resetDut();
    @(posedge clk);
    #1;
    applyStimulus(2, 2, 2, 64'h600, 8'hF0);
    waitDrain("t6_drain", 50);
`ifdef SS_ARB_SRC_TAG_EN
    checkOutput("t6_user", 64'(out_user), 64'hF2);
`else
    checkOutput("t6_user", 64'(out_user), 64'hF0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
